brisc_store_buffer: RTL

Parametrised, coalescing store buffer between the MEM stage and the data cache. It accepts committed SW/SB stores at one per cycle and drains them to the cache in program order through a valid/ready handshake. Byte stores to the youngest pending word are merged into that entry. Loads can look up the buffer and get forwarded data on a full byte-mask hit, or a conflict indication on a partial hit.

---
 rtl/brisc_pkg.sv | 21 ++
 rtl/brisc_stb_match.sv | 49 ++++
 rtl/brisc_store_buffer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared BRISC core widths and types used by the MEM stage and the store buffer.
package brisc_pkg;

    localparam int XLEN          = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int STB_DEPTH     = 4;
    localparam int STB_LANES     = XLEN / 8;
    localparam int STB_LANE_BITS = $clog2(STB_LANES);

    typedef enum logic {
        SIZE_B = 1'b0,
        SIZE_W = 1'b1
    } data_size_e;

    typedef struct packed {
        logic [ADDRESS_WIDTH-STB_LANE_BITS-1:0] word_addr;
        logic [XLEN-1:0]                        data;
        logic [STB_LANES-1:0]                   mask;
    } stb_entry_t;

endpackage

// File: rtl/brisc_stb_match.sv
// Youngest-first address matcher over the occupied store buffer slots.
// Purely combinational: reports the youngest matching slot and whether it covers the load.
module brisc_stb_match #(
    parameter int DEPTH           = 4,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int LANES           = 4
) (
    input  logic [$clog2(DEPTH)-1:0]   head_ptr,
    input  logic                       head_wrap,
    input  logic [$clog2(DEPTH)-1:0]   tail_ptr,
    input  logic                       tail_wrap,
    input  logic [WORD_ADDR_WIDTH-1:0] entry_word_addr [DEPTH],
    input  logic [LANES-1:0]           entry_mask [DEPTH],
    input  logic                       lookup_valid,
    input  logic [WORD_ADDR_WIDTH-1:0] lookup_word_addr,
    input  logic [LANES-1:0]           lookup_mask,
    output logic [$clog2(DEPTH)-1:0]   hit_idx,
    output logic                       hit,
    output logic                       conflict
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   used;
    logic [PTR_W-1:0] idx;
    logic             found;
    logic             covered;

    assign used = {tail_wrap, tail_ptr} - {head_wrap, head_ptr};

    // Walk backwards from tail-1; the first match is the youngest store to that word.
    always_comb begin
        found   = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_ptr - PTR_W'(k + 1);
            if (!found && (k < int'(used)) && (entry_word_addr[idx] == lookup_word_addr)) begin
                found   = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign covered  = (entry_mask[hit_idx] & lookup_mask) == lookup_mask;
    assign hit      = lookup_valid && found && covered;
    assign conflict = lookup_valid && found && !covered;

endmodule

// File: rtl/brisc_store_buffer.sv
// Coalescing store buffer between MEM and the data cache: in-order drain, byte merging
// into the youngest pending word, and load forwarding with partial-hit conflict detection.
module brisc_store_buffer #(
    parameter int DEPTH         = brisc_pkg::STB_DEPTH,
    parameter int XLEN          = brisc_pkg::XLEN,
    parameter int ADDRESS_WIDTH = brisc_pkg::ADDRESS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]   push_addr_i,
    input  logic [XLEN-1:0]            push_data_i,
    input  brisc_pkg::data_size_e      push_size_i,
    output logic                       unaligned_o,
    input  logic [ADDRESS_WIDTH-1:0]   lookup_addr_i,
    input  brisc_pkg::data_size_e      lookup_size_i,
    output logic                       hit_o,
    output logic [XLEN-1:0]            hit_data_o,
    output logic                       conflict_o,
    output logic                       drain_valid_o,
    input  logic                       drain_ready_i,
    output logic [ADDRESS_WIDTH-1:0]   drain_addr_o,
    output logic [XLEN-1:0]            drain_data_o,
    output logic [XLEN/8-1:0]          drain_mask_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    import brisc_pkg::*;

    localparam int LANES     = XLEN / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int WORD_W    = ADDRESS_WIDTH - LANE_BITS;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    // Same layout as stb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WORD_W-1:0] word_addr;
        logic [XLEN-1:0]   data;
        logic [LANES-1:0]  mask;
    } entry_t;

    entry_t           entries_q [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_prev;
    logic             head_wrap;
    logic             tail_wrap;
    logic [PTR_W:0]   used;
    logic             full;
    logic             empty;

    logic [WORD_W-1:0]    push_word;
    logic [LANE_BITS-1:0] push_lane;
    logic [LANES-1:0]     push_mask;
    logic [XLEN-1:0]      push_lanes_data;
    logic [XLEN-1:0]      push_bits;
    logic                 push_misaligned;
    logic                 coalesce_possible;
    logic                 push_accept;
    logic                 do_coalesce;
    logic                 do_alloc;
    logic                 pop;

    logic [WORD_W-1:0]    lookup_word;
    logic [LANE_BITS-1:0] lookup_lane;
    logic [LANES-1:0]     lookup_mask;
    logic                 lookup_valid;
    logic [WORD_W-1:0]    entry_word_addr [DEPTH];
    logic [LANES-1:0]     entry_mask [DEPTH];
    logic [PTR_W-1:0]     match_idx;
    logic                 match_hit;
    logic                 match_conflict;

    assign used      = {tail_wrap, tail_ptr} - {head_wrap, head_ptr};
    assign full      = (tail_ptr == head_ptr) && (tail_wrap != head_wrap);
    assign empty     = (used == '0);
    assign tail_prev = tail_ptr - PTR_W'(1);

    assign push_word       = push_addr_i[ADDRESS_WIDTH-1:LANE_BITS];
    assign push_lane       = push_addr_i[LANE_BITS-1:0];
    assign push_misaligned = (push_size_i == SIZE_W) && (push_lane != '0);
    assign push_mask       = (push_size_i == SIZE_W) ? '1 : (LANES'(1) << push_lane);
    assign push_lanes_data = (push_size_i == SIZE_W) ? push_data_i : {LANES{push_data_i[7:0]}};

    always_comb begin
        push_bits = '0;
        for (int b = 0; b < LANES; b++) begin
            push_bits[b*8 +: 8] = {8{push_mask[b]}};
        end
    end

    // Merging into tail-1 is safe alongside a pop because tail-1 is never the head here.
    assign coalesce_possible = (used >= (PTR_W+1)'(2))
                            && (entries_q[tail_prev].word_addr == push_word)
                            && (tail_prev != head_ptr);

    assign push_ready_o = !full || coalesce_possible;
    assign push_accept  = push_valid_i && push_ready_o && !push_misaligned;
    assign do_coalesce  = push_accept && coalesce_possible;
    assign do_alloc     = push_accept && !coalesce_possible;
    assign pop          = !empty && drain_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_ptr    <= '0;
            head_wrap   <= 1'b0;
            tail_ptr    <= '0;
            tail_wrap   <= 1'b0;
            unaligned_o <= 1'b0;
        end else begin
            unaligned_o <= push_valid_i && push_misaligned;
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
                if (head_ptr == PTR_W'(DEPTH - 1)) begin
                    head_wrap <= ~head_wrap;
                end
            end
            if (do_alloc) begin
                entries_q[tail_ptr].word_addr <= push_word;
                entries_q[tail_ptr].data      <= push_lanes_data & push_bits;
                entries_q[tail_ptr].mask      <= push_mask;
                tail_ptr <= tail_ptr + PTR_W'(1);
                if (tail_ptr == PTR_W'(DEPTH - 1)) begin
                    tail_wrap <= ~tail_wrap;
                end
            end else if (do_coalesce) begin
                entries_q[tail_prev].data <= (entries_q[tail_prev].data & ~push_bits)
                                           | (push_lanes_data & push_bits);
                entries_q[tail_prev].mask <= entries_q[tail_prev].mask | push_mask;
            end
        end
    end

    assign lookup_word  = lookup_addr_i[ADDRESS_WIDTH-1:LANE_BITS];
    assign lookup_lane  = lookup_addr_i[LANE_BITS-1:0];
    assign lookup_valid = !((lookup_size_i == SIZE_W) && (lookup_lane != '0));
    assign lookup_mask  = (lookup_size_i == SIZE_W) ? '1 : (LANES'(1) << lookup_lane);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_word_addr[i] = entries_q[i].word_addr;
            entry_mask[i]      = entries_q[i].mask;
        end
    end

    brisc_stb_match #(
        .DEPTH           (DEPTH),
        .WORD_ADDR_WIDTH (WORD_W),
        .LANES           (LANES)
    ) u_match (
        .head_ptr         (head_ptr),
        .head_wrap        (head_wrap),
        .tail_ptr         (tail_ptr),
        .tail_wrap        (tail_wrap),
        .entry_word_addr  (entry_word_addr),
        .entry_mask       (entry_mask),
        .lookup_valid     (lookup_valid),
        .lookup_word_addr (lookup_word),
        .lookup_mask      (lookup_mask),
        .hit_idx          (match_idx),
        .hit              (match_hit),
        .conflict         (match_conflict)
    );

    assign hit_o      = match_hit;
    assign conflict_o = match_conflict;
    assign hit_data_o = match_hit ? entries_q[match_idx].data : '0;

    assign drain_valid_o = !empty;
    assign drain_addr_o  = empty ? '0 : {entries_q[head_ptr].word_addr, {LANE_BITS{1'b0}}};
    assign drain_data_o  = empty ? '0 : entries_q[head_ptr].data;
    assign drain_mask_o  = empty ? '0 : entries_q[head_ptr].mask;

    assign count_o = CNT_W'(used);
    assign empty_o = empty;

endmodule
